// File: rtl/sa1_bank_mapper.sv
`timescale 1ns/1ps
// sa1_bank_mapper: two-stage SNES-to-SRAM0 address translator with NUM_SLOTS
// double-buffered 1 MiB bank slots. Optional macro BANKMAP_LOCK_EN adds a config lock.
module sa1_bank_mapper #(
   parameter int NUM_SLOTS = 4,
   parameter int BANK_W    = 3,
   localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [23:0]       SNES_ADDR,
   input  logic              addr_strobe,
   input  logic [23:0]       SAVERAM_MASK,
   input  logic [23:0]       ROM_MASK,
   input  logic [4:0]        sa1_bmaps_sbm,
   input  logic              cfg_we,
   input  logic [SLOT_W-1:0] cfg_slot,
   input  logic [BANK_W-1:0] cfg_bank,
   input  logic              cfg_en,
   input  logic              cfg_commit,
`ifdef BANKMAP_LOCK_EN
   input  logic              cfg_lock,
`endif
   output logic [23:0]       ROM_ADDR,
   output logic              ROM_HIT,
   output logic              IS_ROM,
   output logic              IS_SAVERAM,
   output logic              out_valid,
   output logic              commit_pending,
   output logic              locked
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   logic [BANK_W:0]   shadow [NUM_SLOTS];
   logic [BANK_W:0]   active [NUM_SLOTS];
   logic [0:0]        state;
   logic              cfg_we_eff;
   logic              commit_req;
   logic              commit_fire;
   logic [23:0]       saveram_mask_r;
   logic [23:0]       rom_mask_r;

   // Configuration gating: a lock freezes both shadow writes and commits.
`ifdef BANKMAP_LOCK_EN
   logic lock_req;
   logic locked_r;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lock_req <= 1'b0;
         locked_r <= 1'b0;
      end else if (commit_fire) begin
         locked_r <= locked_r | lock_req;
         lock_req <= 1'b0;
      end else if (commit_req && cfg_lock) begin
         lock_req <= 1'b1;
      end
   end

   assign locked     = locked_r;
   assign cfg_we_eff = cfg_we & ~locked_r;
   assign commit_req = cfg_commit & ~locked_r;
`else
   assign locked     = 1'b0;
   assign cfg_we_eff = cfg_we;
   assign commit_req = cfg_commit;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         saveram_mask_r <= '0;
         rom_mask_r     <= '0;
      end else begin
         saveram_mask_r <= SAVERAM_MASK;
         rom_mask_r     <= ROM_MASK;
      end
   end

   // Commit FSM: wait for a cycle with no translation entering or in stage 1.
   logic s1_valid;
   assign commit_fire    = (state == ST_PEND) && !s1_valid && !addr_strobe;
   assign commit_pending = (state == ST_PEND);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else if (state == ST_IDLE && commit_req) state <= ST_PEND;
      else if (commit_fire) state <= ST_IDLE;
   end

   // NOTE: slot arrays are small register files with a defined identity value, so they are reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= {1'b0, BANK_W'(i)};
      end else if (cfg_we_eff) begin
         shadow[cfg_slot] <= {cfg_en, cfg_bank};
      end
   end

   // A write landing on the commit edge is forwarded so it is not lost.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_SLOTS; i++) active[i] <= {1'b0, BANK_W'(i)};
      end else if (commit_fire) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            active[i] <= (cfg_we_eff && cfg_slot == SLOT_W'(i)) ? {cfg_en, cfg_bank} : shadow[i];
      end
   end

   // Stage 1: region decode and slot capture.
   logic              dec_rom;
   logic              dec_sav;
   logic [2:0]        lo_sel3;
   logic [2:0]        hi_sel3;
   logic [SLOT_W-1:0] sel_slot;

   assign dec_rom  = (~SNES_ADDR[22] & SNES_ADDR[15]) | (SNES_ADDR[23] & SNES_ADDR[22]);
   assign dec_sav  = saveram_mask_r[0] &
                     ((SNES_ADDR[23:20] == 4'b0100) |
                      (~SNES_ADDR[22] & ~SNES_ADDR[15] & SNES_ADDR[14] & SNES_ADDR[13]));
   assign lo_sel3  = {1'b0, SNES_ADDR[23], SNES_ADDR[21]};
   assign hi_sel3  = {1'b0, SNES_ADDR[21], SNES_ADDR[20]};
   assign sel_slot = SNES_ADDR[22] ? hi_sel3[SLOT_W-1:0] : lo_sel3[SLOT_W-1:0];

   logic              s1_rom;
   logic              s1_sav;
   logic              s1_hi;
   logic [19:0]       s1_lo_bits;
   logic [19:0]       s1_hi_bits;
   logic [4:0]        s1_sbm;
   logic [SLOT_W-1:0] s1_slot_idx;
   logic [BANK_W:0]   s1_entry;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_valid    <= 1'b0;
         s1_rom      <= 1'b0;
         s1_sav      <= 1'b0;
         s1_hi       <= 1'b0;
         s1_lo_bits  <= '0;
         s1_hi_bits  <= '0;
         s1_sbm      <= '0;
         s1_slot_idx <= '0;
         s1_entry    <= '0;
      end else begin
         s1_valid <= addr_strobe;
         if (addr_strobe) begin
            s1_rom      <= dec_rom;
            s1_sav      <= dec_sav;
            s1_hi       <= SNES_ADDR[22];
            s1_lo_bits  <= {SNES_ADDR[20:16], SNES_ADDR[14:0]};
            s1_hi_bits  <= SNES_ADDR[19:0];
            s1_sbm      <= sa1_bmaps_sbm;
            s1_slot_idx <= sel_slot;
            s1_entry    <= active[sel_slot];
         end
      end
   end

   // Stage 2: address formation; HiROM ignores the slot enable.
   logic [BANK_W-1:0] bank_eff;
   logic [23:0]       rom_addr;
   logic [23:0]       sav_off;
   logic [23:0]       next_addr;

   assign bank_eff  = (s1_entry[BANK_W] | s1_hi) ? s1_entry[BANK_W-1:0] : BANK_W'(s1_slot_idx);
   assign rom_addr  = 24'({bank_eff, s1_hi ? s1_hi_bits : s1_lo_bits}) & rom_mask_r;
   assign sav_off   = s1_hi ? {4'b0, s1_hi_bits} : {6'b0, s1_sbm, s1_hi_bits[12:0]};
   assign next_addr = s1_sav ? (24'hE00000 + (sav_off & saveram_mask_r)) : rom_addr;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid  <= 1'b0;
         ROM_ADDR   <= '0;
         ROM_HIT    <= 1'b0;
         IS_ROM     <= 1'b0;
         IS_SAVERAM <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            ROM_ADDR   <= next_addr;
            ROM_HIT    <= s1_rom | s1_sav;
            IS_ROM     <= s1_rom;
            IS_SAVERAM <= s1_sav;
         end
      end
   end

endmodule

// File: tb/tb_sa1_bank_mapper.sv
`timescale 1ns/1ps
// Directed self-checking bench for sa1_bank_mapper (default parameters).
module tb_sa1_bank_mapper;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [23:0] SNES_ADDR;
   logic        addr_strobe;
   logic [23:0] SAVERAM_MASK;
   logic [23:0] ROM_MASK;
   logic [4:0]  sa1_bmaps_sbm;
   logic        cfg_we;
   logic [1:0]  cfg_slot;
   logic [2:0]  cfg_bank;
   logic        cfg_en;
   logic        cfg_commit;
   logic        cfg_lock;
   logic [23:0] ROM_ADDR;
   logic        ROM_HIT;
   logic        IS_ROM;
   logic        IS_SAVERAM;
   logic        out_valid;
   logic        commit_pending;
   logic        locked;

   int tests = 0;
   int fails = 0;

   sa1_bank_mapper dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .SNES_ADDR      (SNES_ADDR),
      .addr_strobe    (addr_strobe),
      .SAVERAM_MASK   (SAVERAM_MASK),
      .ROM_MASK       (ROM_MASK),
      .sa1_bmaps_sbm  (sa1_bmaps_sbm),
      .cfg_we         (cfg_we),
      .cfg_slot       (cfg_slot),
      .cfg_bank       (cfg_bank),
      .cfg_en         (cfg_en),
      .cfg_commit     (cfg_commit),
`ifdef BANKMAP_LOCK_EN
      .cfg_lock       (cfg_lock),
`endif
      .ROM_ADDR       (ROM_ADDR),
      .ROM_HIT        (ROM_HIT),
      .IS_ROM         (IS_ROM),
      .IS_SAVERAM     (IS_SAVERAM),
      .out_valid      (out_valid),
      .commit_pending (commit_pending),
      .locked         (locked)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"}, ROM_ADDR, 24'h0);
      check({tag, "_valid"}, out_valid, 24'h0);
      check({tag, "_hit"}, ROM_HIT, 24'h0);
      check({tag, "_rom"}, IS_ROM, 24'h0);
      check({tag, "_sav"}, IS_SAVERAM, 24'h0);
      check({tag, "_pend"}, commit_pending, 24'h0);
   endtask

   // One isolated translation: strobe, expect out_valid exactly two edges later, then a single-cycle pulse.
   task automatic xlate(input string tag, input logic [23:0] addr, input logic [23:0] exp_addr,
                        input logic exp_rom, input logic exp_sav);
      SNES_ADDR   = addr;
      addr_strobe = 1'b1;
      step();
      addr_strobe = 1'b0;
      check({tag, "_early"}, out_valid, 24'h0);
      step();
      check({tag, "_valid"}, out_valid, 24'h1);
      check({tag, "_addr"}, ROM_ADDR, exp_addr);
      check({tag, "_rom"}, IS_ROM, exp_rom);
      check({tag, "_sav"}, IS_SAVERAM, exp_sav);
      check({tag, "_hit"}, ROM_HIT, exp_rom | exp_sav);
      step();
      check({tag, "_pulse"}, out_valid, 24'h0);
   endtask

   task automatic write_commit(input string tag, input logic [1:0] slot, input logic [2:0] bank,
                               input logic en);
      cfg_we     = 1'b1;
      cfg_slot   = slot;
      cfg_bank   = bank;
      cfg_en     = en;
      cfg_commit = 1'b1;
      step();
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      check({tag, "_pend"}, commit_pending, 24'h1);
      step();
      check({tag, "_done"}, commit_pending, 24'h0);
   endtask

   initial begin
      RST_N         = 1'b0;
      SNES_ADDR     = '0;
      addr_strobe   = 1'b0;
      SAVERAM_MASK  = 24'h000000;
      ROM_MASK      = 24'hFFFFFF;
      sa1_bmaps_sbm = 5'd0;
      cfg_we        = 1'b0;
      cfg_slot      = '0;
      cfg_bank      = '0;
      cfg_en        = 1'b0;
      cfg_commit    = 1'b0;
      cfg_lock      = 1'b0;
      #12;
      check_all_zero("reset");
      check("reset_locked", locked, 24'h0);
      RST_N = 1'b1;
      step();

      // Identity mapping after reset: LoROM slots select {A23,A21}, disabled -> bank = slot index.
      xlate("id_808000", 24'h808000, 24'h200000, 1'b1, 1'b0);
      xlate("id_208000", 24'h208000, 24'h100000, 1'b1, 1'b0);
      xlate("id_00FFFF", 24'h00FFFF, 24'h007FFF, 1'b1, 1'b0);

      // Enabled LoROM slot.
      write_commit("wc_slot2", 2'd2, 3'd5, 1'b1);
      xlate("lo_en_808123", 24'h808123, 24'h500123, 1'b1, 1'b0);

      // HiROM uses A21:20 and the slot bank regardless of enable.
      xlate("hi_D12345", 24'hD12345, 24'h112345, 1'b1, 1'b0);
      xlate("hi_F08000", 24'hF08000, 24'h308000, 1'b1, 1'b0);
      xlate("hi_E01234", 24'hE01234, 24'h501234, 1'b1, 1'b0);
      ROM_MASK = 24'h0FFFFF;
      step();
      xlate("hi_masked", 24'hD12345, 24'h012345, 1'b1, 1'b0);
      ROM_MASK = 24'hFFFFFF;
      step();

      // Deferred commit under ten back-to-back strobes.
      cfg_we      = 1'b1;
      cfg_slot    = 2'd2;
      cfg_bank    = 3'd3;
      cfg_en      = 1'b1;
      cfg_commit  = 1'b1;
      SNES_ADDR   = 24'h808123;
      addr_strobe = 1'b1;
      step();
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      check("defer_first_valid", out_valid, 24'h0);
      for (int i = 1; i < 10; i++) begin
         step();
         check("defer_pend", commit_pending, 24'h1);
         check("defer_valid", out_valid, 24'h1);
         check("defer_old_map", ROM_ADDR, 24'h500123);
      end
      addr_strobe = 1'b0;
      step();
      check("defer_drain_pend", commit_pending, 24'h1);
      check("defer_drain_addr", ROM_ADDR, 24'h500123);
      step();
      check("defer_applied", commit_pending, 24'h0);
      check("defer_idle_valid", out_valid, 24'h0);
      check("defer_hold_addr", ROM_ADDR, 24'h500123);
      xlate("defer_new_map", 24'h808123, 24'h300123, 1'b1, 1'b0);

      // A write landing on the commit edge is included in that commit.
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      cfg_we     = 1'b1;
      cfg_slot   = 2'd1;
      cfg_bank   = 3'd6;
      cfg_en     = 1'b1;
      step();
      cfg_we = 1'b0;
      check("fwd_done", commit_pending, 24'h0);
      xlate("fwd_208000", 24'h208000, 24'h600000, 1'b1, 1'b0);

      // Save RAM windows.
      SAVERAM_MASK  = 24'h00FFFF;
      sa1_bmaps_sbm = 5'd1;
      step();
      xlate("sav_006010", 24'h006010, 24'hE02010, 1'b0, 1'b1);
      xlate("sav_401234", 24'h401234, 24'hE01234, 1'b0, 1'b1);
      xlate("none_002000", 24'h002000, 24'h002000, 1'b0, 1'b0);
      SAVERAM_MASK = 24'h00FFFE;
      step();
      xlate("sav_absent", 24'h006010, 24'h006010, 1'b0, 1'b0);

      // Reset one cycle after a strobe discards the translation and restores identity slots.
      SNES_ADDR   = 24'h808123;
      addr_strobe = 1'b1;
      step();
      addr_strobe = 1'b0;
      RST_N       = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      check("midrst_valid_hold", out_valid, 24'h0);
      RST_N = 1'b1;
      step();
      check("midrst_valid_after", out_valid, 24'h0);
      check("midrst_addr_after", ROM_ADDR, 24'h0);
      xlate("midrst_identity", 24'h808123, 24'h200123, 1'b1, 1'b0);
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      step();
      xlate("midrst_shadow_id", 24'h808123, 24'h200123, 1'b1, 1'b0);

`ifdef BANKMAP_LOCK_EN
      cfg_commit = 1'b1;
      cfg_lock   = 1'b1;
      step();
      cfg_commit = 1'b0;
      cfg_lock   = 1'b0;
      step();
      check("lock_set", locked, 24'h1);
      cfg_we     = 1'b1;
      cfg_slot   = 2'd0;
      cfg_bank   = 3'd7;
      cfg_en     = 1'b1;
      cfg_commit = 1'b1;
      step();
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      check("lock_ignored_commit", commit_pending, 24'h0);
      step();
      xlate("lock_map", 24'h00FFFF, 24'h007FFF, 1'b1, 1'b0);
      check("lock_still", locked, 24'h1);
`else
      check("lock_tied", locked, 24'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
